// File: rtl/jk_excitation_counter.sv
`default_nettype none
// ============================================================================
// Module      : jk_excitation_counter
// Description : Programmable-modulus up/down counter whose state bits are JK
//               flip-flops. The desired next state is chosen first, the J/K
//               inputs for every bit are derived from the JK excitation table,
//               and the state register is updated only through the JK
//               characteristic equation. The J/K vectors applied at each edge
//               are registered and exported alongside the count.
//
// Ports       : clk      - clock, all state changes on the rising edge
//               clr_n    - synchronous active-low reset (overrides load/en)
//               en       - count enable
//               up       - direction, 1 = increment, 0 = decrement
//               load     - parallel load request (priority over en)
//               load_val - value to load, clamped to mod_m1
//               mod_m1   - terminal value, count range is 0..mod_m1
//               q        - current count (JK flip-flop outputs)
//               j_o      - J vector applied at the most recent edge
//               k_o      - K vector applied at the most recent edge
//               tc       - registered one-cycle terminal-count/wrap pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module jk_excitation_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] mod_m1,
    output logic [W-1:0] q,
    output logic [W-1:0] j_o,
    output logic [W-1:0] k_o,
    output logic         tc
);

    localparam logic [W-1:0] c_zero = '0;
    localparam logic [W-1:0] c_one  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] w_nxt;
    logic         w_tc;
    logic [W-1:0] w_j;
    logic [W-1:0] w_k;
    logic [W-1:0] w_q_jk;
    logic         w_q_at_top;
    logic         w_q_over;
    logic         w_q_zero;
    logic         w_load_over;

    assign w_q_at_top  = (q >= mod_m1);
    assign w_q_over    = (q > mod_m1);
    assign w_q_zero    = (q == c_zero);
    assign w_load_over = (load_val > mod_m1);

    // Next-state selection. A count that is out of range (because mod_m1
    // was lowered underneath it) is folded back into range: counting up
    // wraps to 0 with a tc pulse, counting down lands on mod_m1 without one.
    always_comb begin
        w_nxt = q;
        w_tc  = 1'b0;
        if (load) begin
            w_nxt = w_load_over ? mod_m1 : load_val;
        end else if (en) begin
            if (up) begin
                if (w_q_at_top) begin
                    w_nxt = c_zero;
                    w_tc  = 1'b1;
                end else begin
                    w_nxt = q + c_one;
                end
            end else begin
                if (w_q_zero) begin
                    w_nxt = mod_m1;
                    w_tc  = 1'b1;
                end else if (w_q_over) begin
                    w_nxt = mod_m1;
                end else begin
                    w_nxt = q - c_one;
                end
            end
        end
    end

    // Excitation with don't-cares resolved to 0: J only sets a 0 bit that
    // must become 1, K only clears a 1 bit that must become 0. J and K are
    // therefore never high together, so the toggle case is never used.
    assign w_j = ~q &  w_nxt;
    assign w_k =  q & ~w_nxt;

    // JK characteristic equation, evaluated on the pre-edge state.
    assign w_q_jk = (w_j & ~q) | (~w_k & q);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q   <= '0;
            j_o <= '0;
            k_o <= '0;
            tc  <= 1'b0;
        end else begin
            q   <= w_q_jk;
            j_o <= w_j;
            k_o <= w_k;
            tc  <= w_tc;
        end
    end

    // The characteristic equation must reproduce the chosen next state.
    a_q_follows_nxt : assert property (
        @(posedge clk) clr_n |=> (q == $past(w_nxt))
    );

    // The exported excitation never requests a toggle.
    a_no_toggle : assert property (
        @(posedge clk) (j_o & k_o) == c_zero
    );

endmodule
`default_nettype wire

// File: doc/jk_excitation_counter.md
Name: jk_excitation_counter

Overview:
- Programmable modulus up/down counter. Each state bit is held as a JK flip-flop.
- The block works in the excitation direction. It takes the desired next state, derives the J/K inputs for every bit from the JK excitation table, and updates the state only through the JK characteristic equation.
- The J/K vectors applied at each edge are exported so benches and downstream logic can check flip-flop-level behaviour.
- It sits beside the existing JK/T flip-flop primitives as the standard excitation-driven counter for sequence generators.

Parameters:
- W, 4, counter width in bits (W >= 2).

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- clr_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- en, input, 1, count enable.
- up, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, parallel load request.
- load_val, input, W, value to load.
- mod_m1, input, W, terminal value; the count range is 0..mod_m1 (modulus = mod_m1+1).
- q, output, W, current count (the JK flip-flop outputs).
- j_o, output, W, J vector applied at the most recent edge.
- k_o, output, W, K vector applied at the most recent edge.
- tc, output, 1, terminal-count/wrap pulse, registered, high for one cycle.

Behaviour:
- One clock domain. Reset is synchronous and active-low: when clr_n=0 at a rising clk edge, q=0, j_o=0, k_o=0, tc=0. Reset overrides load and en.
- Priority at each edge (clr_n=1): load > en > hold.
- nxt selection, per case:
  - load: nxt = load_val if load_val <= mod_m1, otherwise mod_m1 (clamp). tc=0.
  - en=1, up=1: if q >= mod_m1, nxt=0 and tc=1 (this includes q out of range after a mod_m1 change). Otherwise nxt=q+1 and tc=0.
  - en=1, up=0: if q==0, nxt=mod_m1 and tc=1. If q > mod_m1, nxt=mod_m1 and tc=0. Otherwise nxt=q-1 and tc=0.
  - hold (en=0, load=0): nxt=q, tc=0.
- Excitation, per bit i, with don't-cares resolved to 0:
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 1->1: J=0, K=0
  - Equivalently j = ~q & nxt and k = q & ~nxt, both computed from the pre-edge q.
- State update uses only the characteristic equation: q <= (j & ~q) | (~k & q), with the j/k computed above. nxt must not be assigned to q directly. An assertion checks q == nxt after every non-reset edge.
- j_o, k_o and tc are registered at the same edge as q, so they describe the transition that produced the current q. Latency from any input to the outputs is 1 cycle.
- j_o & k_o == 0 always; the toggle combination is never generated.
- mod_m1=0: q stays 0. Every enabled cycle gives tc=1, and j_o=k_o=0 when q is already 0.
- mod_m1 is sampled every cycle with no staging; a change takes effect at the next edge.
- No X propagation: all outputs are defined from the first reset onwards.

Test Plan:
- Reset (W=4): clr_n=0 for 2 edges with en=1, load=1, load_val=7 -> q=0, j_o=0, k_o=0, tc=0. Release and drive one enabled up edge -> q=1, j_o=0001.
- Up wrap: mod_m1=9, up=1, en=1 from q=0 for 10 edges -> q goes 1,2,...,9,0. tc=1 only after the 9->0 edge, where j_o=0000 and k_o=1001. The 3->4 edge gives j_o=0100, k_o=0011.
- Down wrap: mod_m1=5, up=0, en=1 from q=0 -> q=5, tc=1, j_o=0101, k_o=0000. The next edge gives q=4, j_o=0000, k_o=0001, tc=0.
- Load: load_val=12 with mod_m1=9 -> q=9 (clamped). load=1 and en=1 together with load_val=3 -> q=3, tc=0 (load wins). en=0, load=0 -> q holds, j_o=k_o=0.
- Modulus change mid-count: q=7, then set mod_m1=3. With up=1 -> q=0, tc=1, k_o=0111. Repeat from q=7 with up=0 -> q=3, tc=0, k_o=0100.
- Reset mid-operation: while counting up at q=6 with en=1, pull clr_n low for one edge -> q=0, j_o=0, k_o=0, tc=0 (no wrap pulse). Counting resumes from 0 on the next edge.
